// File: rtl/ov5642_frame_dma_ctrl_if.sv
// Burst command / completion handshake between the frame DMA sequencer
// and the M00_AXI write-burst master.
interface ov5642_frame_dma_ctrl_if #(
  parameter int ADDR_WIDTH = 32
) ();
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic                  txn_done;
  logic                  txn_error;

  modport master (
    output cmd_valid,
    output cmd_addr,
    input  cmd_ready,
    input  txn_done,
    input  txn_error
  );

  modport slave (
    input  cmd_valid,
    input  cmd_addr,
    output cmd_ready,
    output txn_done,
    output txn_error
  );
endinterface

// File: rtl/ov5642_frame_dma_ctrl.sv
// Frame DMA sequencer: issues one write burst per BURST_WORDS FIFO words into
// ping-pong DDR frame buffers and keeps a sticky pending/ack interrupt set.
module ov5642_frame_dma_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int BURST_WORDS = 16,
  parameter int LVL_WIDTH   = 11,
  parameter int CNT_WIDTH   = 12
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  cfg_enable,
  input  logic [ADDR_WIDTH-1:0] cfg_buf0_addr,
  input  logic [ADDR_WIDTH-1:0] cfg_buf1_addr,
  input  logic [CNT_WIDTH-1:0]  cfg_lines,
  input  logic [CNT_WIDTH-1:0]  cfg_line_words,
  input  logic                  cfg_gie,
  input  logic [2:0]            cfg_ien,
  input  logic                  frame_start,
  input  logic [LVL_WIDTH-1:0]  fifo_level,
  ov5642_frame_dma_ctrl_if.master cmd_if,
  input  logic [2:0]            ack,
  output logic [2:0]            pend,
  output logic                  irq,
  output logic                  active_buf,
  output logic                  busy
);

  localparam logic [LVL_WIDTH-1:0]  BURST_LVL = LVL_WIDTH'(BURST_WORDS);
  localparam logic [CNT_WIDTH-1:0]  BURST_CNT = CNT_WIDTH'(BURST_WORDS);
  localparam logic [ADDR_WIDTH-1:0] STRIDE    = ADDR_WIDTH'(BURST_WORDS * (DATA_WIDTH / 8));

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_FRAME = 3'd1,
    WAIT_DATA  = 3'd2,
    ISSUE      = 3'd3,
    WAIT_DONE  = 3'd4,
    ERROR      = 3'd5
  } state_t;

  state_t                state_r, state_n;
  logic [ADDR_WIDTH-1:0] addr_r, addr_n;
  logic [CNT_WIDTH-1:0]  word_cnt_r, word_n;
  logic [CNT_WIDTH-1:0]  line_cnt_r, line_n;
  logic                  active_buf_r, active_buf_n;
  logic [ADDR_WIDTH-1:0] sh_buf0_r, sh_buf1_r;
  logic [CNT_WIDTH-1:0]  sh_lines_r, sh_line_words_r;
  logic [2:0]            pend_r, pend_set_s;
  logic                  irq_r, cmd_valid_r, busy_r, load_s;
  logic [CNT_WIDTH-1:0]  word_inc_s, line_inc_s;

  assign word_inc_s       = word_cnt_r + BURST_CNT;
  assign line_inc_s       = line_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  assign cmd_if.cmd_valid = cmd_valid_r;
  assign cmd_if.cmd_addr  = addr_r;
  assign pend             = pend_r;
  assign irq              = irq_r;
  assign active_buf       = active_buf_r;
  assign busy             = busy_r;

  // FSM state register
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next state, datapath updates and status set requests
  always_comb begin
    state_n      = state_r;
    addr_n       = addr_r;
    word_n       = word_cnt_r;
    line_n       = line_cnt_r;
    active_buf_n = active_buf_r;
    pend_set_s   = 3'b000;
    load_s       = 1'b0;
    case (state_r)
      IDLE: begin
        load_s = 1'b1;
        if (cfg_enable) state_n = WAIT_FRAME;
        else            state_n = IDLE;
      end
      WAIT_FRAME: begin
        if (!cfg_enable) begin
          state_n = IDLE;
        end else if (frame_start) begin
          line_n  = {CNT_WIDTH{1'b0}};
          word_n  = {CNT_WIDTH{1'b0}};
          addr_n  = active_buf_r ? sh_buf1_r : sh_buf0_r;
          state_n = WAIT_DATA;
        end else begin
          state_n = WAIT_FRAME;
        end
      end
      WAIT_DATA: begin
        if (!cfg_enable)                  state_n = IDLE;
        else if (fifo_level >= BURST_LVL) state_n = ISSUE;
        else                              state_n = WAIT_DATA;
      end
      ISSUE: begin
        // Disable is honoured only after the accepted burst completes.
        if (cmd_if.cmd_ready) state_n = WAIT_DONE;
        else                  state_n = ISSUE;
      end
      WAIT_DONE: begin
        if (cmd_if.txn_done && cmd_if.txn_error) begin
          pend_set_s[1] = 1'b1;
          state_n       = ERROR;
        end else if (cmd_if.txn_done) begin
          addr_n = addr_r + STRIDE;
          if (word_inc_s == sh_line_words_r) begin
            word_n = {CNT_WIDTH{1'b0}};
            line_n = line_inc_s;
            if (line_inc_s == sh_lines_r) begin
              pend_set_s[0] = 1'b1;
              active_buf_n  = ~active_buf_r;
              load_s        = 1'b1;
              state_n       = cfg_enable ? WAIT_FRAME : IDLE;
            end else begin
              state_n = cfg_enable ? WAIT_DATA : IDLE;
            end
          end else begin
            word_n  = word_inc_s;
            state_n = cfg_enable ? WAIT_DATA : IDLE;
          end
        end else begin
          state_n = WAIT_DONE;
        end
      end
      ERROR: begin
        if (!cfg_enable) state_n = IDLE;
        else             state_n = ERROR;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    if (frame_start && (state_r == WAIT_DATA || state_r == ISSUE || state_r == WAIT_DONE)) begin
      pend_set_s[2] = 1'b1;
    end else begin
      pend_set_s[2] = pend_set_s[2];
    end
  end

  // Datapath, shadow config, registered outputs and interrupt status
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      addr_r          <= {ADDR_WIDTH{1'b0}};
      word_cnt_r      <= {CNT_WIDTH{1'b0}};
      line_cnt_r      <= {CNT_WIDTH{1'b0}};
      active_buf_r    <= 1'b0;
      sh_buf0_r       <= {ADDR_WIDTH{1'b0}};
      sh_buf1_r       <= {ADDR_WIDTH{1'b0}};
      sh_lines_r      <= {CNT_WIDTH{1'b0}};
      sh_line_words_r <= {CNT_WIDTH{1'b0}};
      pend_r          <= 3'b000;
      irq_r           <= 1'b0;
      cmd_valid_r     <= 1'b0;
      busy_r          <= 1'b0;
    end else begin
      addr_r       <= addr_n;
      word_cnt_r   <= word_n;
      line_cnt_r   <= line_n;
      active_buf_r <= active_buf_n;
      if (load_s) begin
        sh_buf0_r       <= cfg_buf0_addr;
        sh_buf1_r       <= cfg_buf1_addr;
        sh_lines_r      <= cfg_lines;
        sh_line_words_r <= cfg_line_words;
      end
      // A set request wins over an ack of the same bit.
      pend_r      <= (pend_r & ~ack) | pend_set_s;
      irq_r       <= cfg_gie & (|(pend_r & cfg_ien));
      cmd_valid_r <= (state_n == ISSUE);
      busy_r      <= (state_n != IDLE);
    end
  end

endmodule
